// File: rtl/reg_bank_ctrl_pkg.sv
// Shared types and defaults for the register-bank access controller.
//
// Contents:
//   DEF_WIDTH / DEF_NREG : default data width and register count
//   op_e                 : command opcode encoding carried on cmd_op
//   state_e              : controller sequencing states
package reg_bank_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREG  = 8;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_COPY  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_CAP  = 3'd3,
    ST_RSP  = 3'd4,
    ST_CPW  = 3'd5
  } state_e;

endpackage

// File: rtl/reg_bank_ctrl_sel_dec.sv
// reg_sel_dec: register index to one-hot select decoder.
//
// Ports:
//   idx_i : register index (IW bits)
//   en_i  : select enable
//   sel_o : NREG-bit one-hot select; all-zero when en_i is low or idx_i >= NREG
//
// An index at or beyond NREG matches no bit position, so out-of-range
// accesses fall out of the decode without a separate range check.
module reg_sel_dec #(
  parameter int NREG = 8,
  parameter int IW   = $clog2(NREG)
) (
  input  logic [IW-1:0]   idx_i,
  input  logic            en_i,
  output logic [NREG-1:0] sel_o
);

  for (genvar gi = 0; gi < NREG; gi++) begin : g_sel
    assign sel_o[gi] = en_i && (idx_i == IW'(gi));
  end

endmodule

// File: rtl/reg_bank_ctrl.sv
// reg_bank_ctrl: command-driven access controller for a bank of NREG
// REG_16-style registers.
//
// Accepts command beats (NOP / WRITE / READ / COPY), drives per-register
// one-hot W / RA / RB strobes and write data I, samples the shared OutA /
// OutB buses and returns READ results through a valid/ready response.
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   cmd_valid / cmd_ready     : command handshake (ready only when idle)
//   cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_data : command fields
//   W, RA, RB                 : one-hot write / read-A / read-B strobes
//   I                         : write data to the bank (0 when W is idle)
//   OutA, OutB                : shared read buses from the bank
//   rsp_valid / rsp_ready     : READ response handshake
//   rsp_a, rsp_b              : captured read data
//   err (REG_BANK_CTRL_ERR_EN only) : one-cycle pulse, the cycle after
//                               acceptance, when the op uses an index >= NREG
//
// Optional feature macro: REG_BANK_CTRL_ERR_EN adds the err output.
module reg_bank_ctrl
  import reg_bank_pkg::*;
#(
  parameter int NREG  = DEF_NREG,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IW-1:0]    cmd_dst,
  input  logic [IW-1:0]    cmd_srca,
  input  logic [IW-1:0]    cmd_srcb,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [NREG-1:0]  W,
  output logic [NREG-1:0]  RA,
  output logic [NREG-1:0]  RB,
  output logic [WIDTH-1:0] I,
  input  logic [WIDTH-1:0] OutA,
  input  logic [WIDTH-1:0] OutB,
`ifdef REG_BANK_CTRL_ERR_EN
  output logic             err,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_a,
  output logic [WIDTH-1:0] rsp_b
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [IW-1:0]     dst_q, dst_d;
  logic [IW-1:0]     srca_q, srca_d;
  logic [IW-1:0]     srcb_q, srcb_d;
  logic [WIDTH-1:0]  data_q, data_d;
  // COPY source value, kept apart from rsp_a so a COPY never disturbs the
  // last READ response.
  logic [WIDTH-1:0]  cpy_q, cpy_d;
  logic [WIDTH-1:0]  rsp_a_q, rsp_a_d;
  logic [WIDTH-1:0]  rsp_b_q, rsp_b_d;

  logic              w_en, ra_en, rb_en;

  // Next-state and field capture.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    srca_d  = srca_q;
    srcb_d  = srcb_q;
    data_d  = data_q;
    cpy_d   = cpy_q;
    rsp_a_d = rsp_a_q;
    rsp_b_d = rsp_b_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d   = op_e'(cmd_op);
          dst_d  = cmd_dst;
          srca_d = cmd_srca;
          srcb_d = cmd_srcb;
          data_d = cmd_data;
          case (op_e'(cmd_op))
            OP_WRITE:         state_d = ST_WR;
            OP_READ, OP_COPY: state_d = ST_RD;
            default:          state_d = ST_IDLE;
          endcase
        end
      end
      ST_WR:  state_d = ST_IDLE;
      ST_RD:  state_d = ST_CAP;
      ST_CAP: begin
        // The read strobes have been up for two cycles; the bank buses
        // are settled and sampled on the edge that leaves CAP.
        if (op_q == OP_READ) begin
          rsp_a_d = OutA;
          rsp_b_d = OutB;
          state_d = ST_RSP;
        end else begin
          cpy_d   = OutA;
          state_d = ST_CPW;
        end
      end
      ST_RSP: if (rsp_ready) state_d = ST_IDLE;
      ST_CPW: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      dst_q   <= '0;
      srca_q  <= '0;
      srcb_q  <= '0;
      data_q  <= '0;
      cpy_q   <= '0;
      rsp_a_q <= '0;
      rsp_b_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
      data_q  <= data_d;
      cpy_q   <= cpy_d;
      rsp_a_q <= rsp_a_d;
      rsp_b_q <= rsp_b_d;
    end
  end

  // Strobe enables. Write states and read states are disjoint, so W can
  // never coincide with RA or RB.
  assign w_en  = (state_q == ST_WR) || (state_q == ST_CPW);
  assign ra_en = (state_q == ST_RD) || (state_q == ST_CAP);
  assign rb_en = ra_en && (op_q == OP_READ);

  reg_sel_dec #(.NREG(NREG), .IW(IW)) u_w_dec (
    .idx_i (dst_q),
    .en_i  (w_en),
    .sel_o (W)
  );

  reg_sel_dec #(.NREG(NREG), .IW(IW)) u_ra_dec (
    .idx_i (srca_q),
    .en_i  (ra_en),
    .sel_o (RA)
  );

  reg_sel_dec #(.NREG(NREG), .IW(IW)) u_rb_dec (
    .idx_i (srcb_q),
    .en_i  (rb_en),
    .sel_o (RB)
  );

  // Gate I on the decoded strobe so a suppressed (out-of-range) write
  // also leaves the data bus at zero.
  assign I = (|W) ? ((state_q == ST_WR) ? data_q : cpy_q) : '0;

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RSP);
  assign rsp_a     = rsp_a_q;
  assign rsp_b     = rsp_b_q;

`ifdef REG_BANK_CTRL_ERR_EN
  localparam logic [IW:0] NREG_W = (IW+1)'(NREG);

  logic err_q, err_d;

  function automatic logic oob(input logic [IW-1:0] idx);
    return {1'b0, idx} >= NREG_W;
  endfunction

  // Only the indices the accepted op actually uses are checked.
  always_comb begin
    err_d = 1'b0;
    if (cmd_valid && cmd_ready) begin
      case (op_e'(cmd_op))
        OP_WRITE: err_d = oob(cmd_dst);
        OP_READ:  err_d = oob(cmd_srca) || oob(cmd_srcb);
        OP_COPY:  err_d = oob(cmd_srca) || oob(cmd_dst);
        default:  err_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: doc/reg_bank_ctrl.md
# reg_bank_ctrl

Command-driven access controller for a bank of NREG 16-bit registers built from REG_16 cells. It is the initiator side of the REG_16 port: it turns command beats into per-register W/RA/RB strobes and data on I, samples the shared OutA/OutB buses, and returns read data through a valid/ready response. It sits between the datapath sequencer and the register bank.

## Interface
- NREG, 8, number of registers in the bank (2..16)
- WIDTH, 16, data width
- IW, $clog2(NREG), index width
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command beat valid
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  0 NOP, 1 WRITE, 2 READ, 3 COPY
- cmd_dst  in  IW  write or copy destination
- cmd_srca  in  IW  read port A source, also the COPY source
- cmd_srcb  in  IW  read port B source
- cmd_data  in  WIDTH  WRITE data
- W  out  NREG  one-hot write strobe, one bit per register
- RA  out  NREG  one-hot read-A enable
- RB  out  NREG  one-hot read-B enable
- I  out  WIDTH  write data to the bank
- OutA  in  WIDTH  shared read-A bus from the bank
- OutB  in  WIDTH  shared read-B bus from the bank
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  response consumer ready
- rsp_a  out  WIDTH  captured OutA
- rsp_b  out  WIDTH  captured OutB

## Operation
- States: IDLE, WR, RD, CAP, RSP, CPW.
- cmd_ready is 1 only in IDLE. A command is accepted on cmd_valid && cmd_ready, and its fields are registered on acceptance.
- NOP: accepted, no strobes, stays in IDLE.
- WRITE: IDLE→WR. In WR, W[dst]=1 and I=data; then WR→IDLE.
- READ: IDLE→RD→CAP→RSP.
  - In RD and CAP, RA[srca]=1 and RB[srcb]=1.
  - At the end of CAP, OutA and OutB are latched into rsp_a and rsp_b.
  - In RSP, RA=RB=0 and rsp_valid=1, held until rsp_ready; then RSP→IDLE.
- COPY: IDLE→RD→CAP→CPW.
  - RD and CAP assert RA[srca] only.
  - CPW asserts W[dst] with I=latched OutA, then CPW→IDLE.
  - COPY produces no response, and rsp_a/rsp_b keep their previous values.
- At most one bit set in each of W, RA, RB. W is never asserted in the same cycle as RA or RB.
- I=0 whenever W=0.
- Out-of-range index (≥NREG): the matching strobe is suppressed.
  - A READ of such a port returns 0 on that port.
  - A WRITE or COPY to such a destination writes nothing; the FSM still walks the same states.
- srca==srcb is legal. COPY with dst==srca is legal and rewrites the same value.

## Timing
- Reset: state IDLE, cmd_ready=1, W=RA=RB=0, I=0, rsp_valid=0, rsp_a=rsp_b=0.
- With rst high, all outputs take their reset values on the next edge regardless of state. An in-flight command is dropped and no response is issued.
- WRITE accepted at edge N: W high during cycle N+1 only; cmd_ready high again from N+2. Throughput is 1 write per 2 cycles.
- READ accepted at N: strobes high during N+1 and N+2; OutA/OutB sampled at edge N+3; rsp_valid high from N+3. Minimum 4 cycles per read with rsp_ready tied high.
- COPY accepted at N: RA during N+1 and N+2; W[dst] during N+3; cmd_ready high from N+4.
- rsp_a and rsp_b stay stable while rsp_valid && !rsp_ready.
- cmd_* fields are don't-care outside the accepting cycle.

## Configuration
- REG_BANK_CTRL_ERR_EN defined:
  - Adds output err (1 bit).
  - err is pulsed for one cycle, the cycle after acceptance, when any index used by the op is ≥NREG.
  - err resets to 0.
- Undefined: no err port; out-of-range accesses are silently suppressed as described under Operation.

## Structure
- Package reg_bank_pkg:
  - op encoding enum (NOP/WRITE/READ/COPY)
  - state enum
  - default WIDTH/NREG constants
- Sub-module reg_sel_dec: index + enable → NREG-bit one-hot. Output is all-zero when the enable is low or the index is ≥NREG. Instantiated three times, for W, RA and RB.

## Test plan
- Reset then WRITE dst=3 data=16'h0099 → W=8'b0000_1000 for exactly 1 cycle with I=16'h0099; cmd_ready low that cycle, high the next.
- WRITE r5=16'h0555, then READ srca=5 srcb=3 with a bank model → RA=8'b0010_0000 and RB=8'b0000_1000 for 2 cycles; rsp_valid with rsp_a=16'h0555, rsp_b=16'h0099.
- READ with rsp_ready held low for 5 cycles → rsp_valid and data stable all 5 cycles; cmd_ready stays low until the cycle after the handshake.
- COPY srca=5 dst=1 → r1 reads back 16'h0555; W never overlaps RA; no rsp_valid.
- NREG=6, READ srca=7 → RA all-zero, rsp_a=0; with REG_BANK_CTRL_ERR_EN, err pulses once.
- rst asserted during CAP of a READ → next cycle all strobes 0, rsp_valid 0, cmd_ready 1; no response issued.
